ila_capture_ctrl: RTL and testbench

- Capture/readout sequencer for the ILA sample BRAM.
- Drives the BRAM write enable and write address as a circular buffer, keeping a programmable number of pre-trigger samples.
- Stops after a full window of 2**ADDR_WIDTH samples, then sequences readout from the oldest sample to the newest.
- Sits between the trigger logic / host interface and the BRAM; the BRAM read clock is tied to clk.

---
 rtl/ila_capture_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ila_capture_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: capture/readout sequencer for the ILA sample BRAM.
// Fills the BRAM as a circular buffer and keeps P pre-trigger samples.
// It stops after a window of D = 2**ADDR_WIDTH samples.
// It then replays that window from the oldest sample to the newest.
//
// Ports:
//   clk          single clock (capture, readout, BRAM read clock)
//   rst_n        synchronous active-low reset
//   arm          pulse, start a capture from IDLE or DONE
//   abort        pulse, return to IDLE from any state
//   trigger      trigger condition, sampled every cycle
//   pre_trigger  pre-trigger sample count P, latched on arm
//   rd_next      request one readout sample (DONE/READ only)
//   we           BRAM write enable
//   addr_write   BRAM write address
//   addr_read    BRAM read address
//   rd_valid     BRAM output holds the requested sample this cycle
//   rd_last      rd_valid qualifier for the newest sample
//   busy         capture in progress (FILL, WAIT_TRIG, POST)
//   done         window captured (DONE, READ)
//   trig_addr    address of the trigger sample
module ila_capture_ctrl #(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trigger,
   input  logic [ADDR_WIDTH-1:0] pre_trigger,
   input  logic                  rd_next,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr_write,
   output logic [ADDR_WIDTH-1:0] addr_read,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WAIT_TRIG,
      S_POST,
      S_DONE,
      S_READ
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] C_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] p_lat;
   // Shared counter: pre-count in FILL, post-count in POST,
   // read-count in DONE/READ.
   logic [ADDR_WIDTH:0]   cnt;

   logic [ADDR_WIDTH:0]   post_len;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic                  rd_ok;
   logic                  rd_fire;
   logic                  rd_final;

   assign post_len   = DEPTH - C_ONE - {1'b0, p_lat};
   assign start_addr = trig_addr - p_lat;
   assign rd_ok      = (state == S_DONE) || (state == S_READ);
   // An arm in DONE restarts capture, so it wins over rd_next there.
   // abort does not block the request: it is still issued and answered.
   assign rd_fire    = rd_ok && rd_next &&
                       !((state == S_DONE) && arm && !abort);
   assign rd_final   = (cnt == DEPTH - C_ONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         p_lat      <= '0;
         cnt        <= '0;
         we         <= 1'b0;
         addr_write <= '0;
         addr_read  <= '0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         trig_addr  <= '0;
      end else begin
         rd_valid <= rd_fire;
         rd_last  <= rd_fire && rd_final && !abort;

         if (abort) begin
            state <= S_IDLE;
            we    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE, S_DONE: begin
                  if (arm) begin
                     p_lat      <= pre_trigger;
                     addr_write <= '0;
                     cnt        <= '0;
                     we         <= 1'b1;
                     busy       <= 1'b1;
                     done       <= 1'b0;
                     state      <= (pre_trigger == '0) ? S_WAIT_TRIG
                                                       : S_FILL;
                  end else if (rd_fire) begin
                     if (rd_final) begin
                        addr_read <= start_addr;
                        cnt       <= '0;
                        state     <= S_DONE;
                     end else begin
                        addr_read <= addr_read + A_ONE;
                        cnt       <= cnt + C_ONE;
                        state     <= S_READ;
                     end
                  end
               end

               S_FILL: begin
                  addr_write <= addr_write + A_ONE;
                  cnt        <= cnt + C_ONE;
                  if (cnt + C_ONE == {1'b0, p_lat}) begin
                     state <= S_WAIT_TRIG;
                  end
               end

               S_WAIT_TRIG: begin
                  addr_write <= addr_write + A_ONE;
                  if (trigger) begin
                     trig_addr <= addr_write;
                     if (post_len == C_ZERO) begin
                        // Trigger sample completes the window.
                        addr_read <= addr_write - p_lat;
                        cnt       <= '0;
                        we        <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                     end else begin
                        cnt   <= post_len;
                        state <= S_POST;
                     end
                  end
               end

               S_POST: begin
                  addr_write <= addr_write + A_ONE;
                  cnt        <= cnt - C_ONE;
                  if (cnt == C_ONE) begin
                     addr_read <= start_addr;
                     cnt       <= '0;
                     we        <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end
               end

               S_READ: begin
                  if (rd_fire) begin
                     if (rd_final) begin
                        addr_read <= start_addr;
                        cnt       <= '0;
                        state     <= S_DONE;
                     end else begin
                        addr_read <= addr_read + A_ONE;
                        cnt       <= cnt + C_ONE;
                     end
                  end
               end

               default: begin
                  state <= S_IDLE;
                  we    <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: directed bench for ila_capture_ctrl, D = 8.
// Exercises capture, readout, abort and reset with fixed expectations.
module tb_ila_capture_ctrl;

   localparam int AW = 3;
   localparam int D  = 8;

   logic          clk;
   logic          rst_n;
   logic          arm;
   logic          abort;
   logic          trigger;
   logic [AW-1:0] pre_trigger;
   logic          rd_next;
   logic          we;
   logic [AW-1:0] addr_write;
   logic [AW-1:0] addr_read;
   logic          rd_valid;
   logic          rd_last;
   logic          busy;
   logic          done;
   logic [AW-1:0] trig_addr;

   int n_cmp;
   int n_err;

   ila_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm         (arm),
      .abort       (abort),
      .trigger     (trigger),
      .pre_trigger (pre_trigger),
      .rd_next     (rd_next),
      .we          (we),
      .addr_write  (addr_write),
      .addr_read   (addr_read),
      .rd_valid    (rd_valid),
      .rd_last     (rd_last),
      .busy        (busy),
      .done        (done),
      .trig_addr   (trig_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue n requests starting at the k-th sample of the window.
   // gap = cycles between requests (1 = back-to-back).
   task automatic read_seq(input int start, input int first,
                           input int n, input int gap);
      for (int k = first; k < first + n; k++) begin
         chk("rd_addr", 32'(addr_read), 32'((start + k) % D));
         rd_next = 1'b1;
         tick();
         rd_next = 1'b0;
         chk("rd_valid", 32'(rd_valid), 32'd1);
         chk("rd_last", 32'(rd_last), 32'(k == D - 1));
         for (int g = 1; g < gap; g++) begin
            tick();
            chk("rd_gap", 32'(rd_valid), 32'd0);
         end
      end
   endtask

   // Bounded wait for done; expiry counts as a failed comparison.
   task automatic wait_done(output int writes);
      writes = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (we) writes++;
         tick();
      end
      chk("wait_done", 32'(done), 32'd1);
   endtask

   initial begin
      int w;
      n_cmp       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      arm         = 1'b0;
      abort       = 1'b0;
      trigger     = 1'b0;
      pre_trigger = '0;
      rd_next     = 1'b0;
      tick();
      tick();
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_awr", 32'(addr_write), 32'd0);
      chk("rst_ard", 32'(addr_read), 32'd0);
      rst_n = 1'b1;

      // P=3, trigger held from arm: ignored in FILL, hits at addr 3.
      arm = 1'b1; pre_trigger = 3; trigger = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < D; i++) begin
         chk("t1_we", 32'(we), 32'd1);
         chk("t1_awr", 32'(addr_write), 32'(i));
         chk("t1_busy", 32'(busy), 32'd1);
         tick();
      end
      trigger = 1'b0;
      chk("t1_we_off", 32'(we), 32'd0);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy_off", 32'(busy), 32'd0);
      chk("t1_trig", 32'(trig_addr), 32'd3);
      read_seq(0, 0, D, 1);
      chk("t1_restart", 32'(addr_read), 32'd0);
      chk("t1_done2", 32'(done), 32'd1);
      read_seq(0, 0, D, 3);
      chk("t1_restart2", 32'(addr_read), 32'd0);

      // P=2, trigger 11 cycles into WAIT_TRIG: trig 5, start 3.
      arm = 1'b1; pre_trigger = 2;
      tick();
      arm = 1'b0;
      tick();
      tick();
      chk("t2_wait_addr", 32'(addr_write), 32'd2);
      for (int i = 0; i < 11; i++) tick();
      chk("t2_pretrig", 32'(addr_write), 32'd5);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk("t2_trig", 32'(trig_addr), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_post_we", 32'(we), 32'd1);
         chk("t2_post_awr", 32'(addr_write), 32'((6 + i) % D));
         tick();
      end
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_we_off", 32'(we), 32'd0);
      chk("t2_start", 32'(addr_read), 32'd3);
      read_seq(3, 0, D, 1);
      chk("t2_restart", 32'(addr_read), 32'd3);

      // P=0: straight to WAIT_TRIG, start equals trig_addr.
      arm = 1'b1; pre_trigger = 0;
      tick();
      arm = 1'b0;
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_awr", 32'(addr_write), 32'd0);
      tick();
      tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk("t3_trig", 32'(trig_addr), 32'd2);
      wait_done(w);
      chk("t3_posts", 32'(w), 32'd7);
      chk("t3_start", 32'(addr_read), 32'd2);

      // P=7: no POST writes, 8 writes in the window.
      arm = 1'b1; pre_trigger = 7; trigger = 1'b1;
      tick();
      arm = 1'b0;
      wait_done(w);
      trigger = 1'b0;
      chk("t4_writes", 32'(w), 32'd8);
      chk("t4_trig", 32'(trig_addr), 32'd7);
      chk("t4_start", 32'(addr_read), 32'd0);

      // abort during POST.
      arm = 1'b1; pre_trigger = 1; trigger = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      tick();
      trigger = 1'b0;
      chk("t5_in_post", 32'(addr_write), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_we", 32'(we), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk("t5_idle_we", 32'(we), 32'd0);

      // abort during READ together with the 8th request.
      arm = 1'b1; pre_trigger = 4; trigger = 1'b1;
      tick();
      arm = 1'b0;
      wait_done(w);
      trigger = 1'b0;
      chk("t6_trig", 32'(trig_addr), 32'd4);
      read_seq(0, 0, D - 1, 1);
      chk("t6_last_addr", 32'(addr_read), 32'd7);
      rd_next = 1'b1; abort = 1'b1;
      tick();
      rd_next = 1'b0; abort = 1'b0;
      chk("t6_valid", 32'(rd_valid), 32'd1);
      chk("t6_last", 32'(rd_last), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      tick();
      chk("t6_once", 32'(rd_valid), 32'd0);
      rd_next = 1'b1;
      tick();
      rd_next = 1'b0;
      chk("t6_idle_rd", 32'(rd_valid), 32'd0);

      // arm and abort together in IDLE.
      arm = 1'b1; abort = 1'b1; pre_trigger = 2;
      tick();
      arm = 1'b0; abort = 1'b0;
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_we", 32'(we), 32'd0);
      tick();
      chk("t7_busy2", 32'(busy), 32'd0);

      // Reset mid-WAIT_TRIG, then a clean capture.
      arm = 1'b1; pre_trigger = 2;
      tick();
      arm = 1'b0;
      tick();
      tick();
      tick();
      chk("t8_pre", 32'(addr_write), 32'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t8_we", 32'(we), 32'd0);
      chk("t8_busy", 32'(busy), 32'd0);
      chk("t8_done", 32'(done), 32'd0);
      chk("t8_awr", 32'(addr_write), 32'd0);
      chk("t8_ard", 32'(addr_read), 32'd0);
      chk("t8_trig", 32'(trig_addr), 32'd0);
      chk("t8_valid", 32'(rd_valid), 32'd0);
      tick();
      chk("t8_idle", 32'(we), 32'd0);
      arm = 1'b1; pre_trigger = 3; trigger = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < D; i++) begin
         chk("t8_awr_seq", 32'(addr_write), 32'(i));
         tick();
      end
      trigger = 1'b0;
      chk("t8_trig2", 32'(trig_addr), 32'd3);
      chk("t8_done2", 32'(done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
